// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared width default and FSM state encoding for the MaxNet I/O sequencer
// Purpose: common definitions imported by the sequencer and its slot bank.
// Contents: WIDTH_DEFAULT (candidate width), state_t (2-bit FSM encoding).
package maxnet_pkg;

  localparam int WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_START  = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/maxnet_slot_bank.sv
// rtl/maxnet_slot_bank.sv - four candidate registers feeding the MaxNet datapath
// Purpose: holds X1..X4; one slot written per accepted input, all held otherwise.
// Ports:
//   clk, rst         clock, synchronous active-high reset (clears all slots)
//   wr_en            write the slot selected by wr_idx this cycle
//   wr_idx [1:0]     slot index, 0 -> X1 .. 3 -> X4
//   wr_data [W-1:0]  value to store
//   X1..X4 [W-1:0]   registered slot contents
module maxnet_slot_bank
  import maxnet_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] X1,
  output logic [WIDTH-1:0] X2,
  output logic [WIDTH-1:0] X3,
  output logic [WIDTH-1:0] X4
);

  always_ff @(posedge clk) begin
    if (rst) begin
      X1 <= '0;
      X2 <= '0;
      X3 <= '0;
      X4 <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        2'd0:    X1 <= wr_data;
        2'd1:    X2 <= wr_data;
        2'd2:    X3 <= wr_data;
        default: X4 <= wr_data;
      endcase
    end
  end

endmodule

// File: rtl/maxnet_io_sequencer.sv
// rtl/maxnet_io_sequencer.sv - input collection, start/finish handshake and result return for MaxNet
// Purpose: gathers four candidates from a valid/ready stream, pulses start, waits for
//   finish (with settle window and watchdog), returns the winner on a valid/ready port.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_data/in_valid/in_ready   candidate input stream (accepted only in FILL)
//   X1..X4                      candidates to the datapath, held outside FILL
//   start                       one-cycle pulse to the MaxNet controller
//   finish, max                 datapath convergence flag and winner value
//   res_data/res_valid/res_ready result stream; res_timeout=1 marks a watchdog expiry
module maxnet_io_sequencer
  import maxnet_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int SETTLE   = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] X1,
  output logic [WIDTH-1:0] X2,
  output logic [WIDTH-1:0] X3,
  output logic [WIDTH-1:0] X4,
  output logic             start,
  input  logic             finish,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_timeout
);

  localparam int               WDW      = $clog2(MAX_WAIT + 1);
  localparam logic [WDW-1:0]   SETTLE_W = WDW'(SETTLE);
  localparam logic [WDW-1:0]   LAST_W   = WDW'(MAX_WAIT - 1);

  state_t         state, state_nxt;
  logic [1:0]     cnt;
  logic [WDW-1:0] wdog;
  logic           accept_in;
  logic           finish_hit;
  logic           expire;

  assign accept_in = in_valid & in_ready;

  maxnet_slot_bank #(.WIDTH(WIDTH)) u_slots (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_in),
    .wr_idx  (cnt),
    .wr_data (in_data),
    .X1      (X1),
    .X2      (X2),
    .X3      (X3),
    .X4      (X4)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    start      = 1'b0;
    finish_hit = 1'b0;
    expire     = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && cnt == 2'd3) state_nxt = S_START;
      end
      S_START: begin
        start     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // finish is masked while the datapath pipeline flushes; a late finish
        // beats the watchdog when both land on the final cycle
        finish_hit = finish && (wdog >= SETTLE_W);
        expire     = !finish_hit && (wdog == LAST_W);
        if (finish_hit || expire) state_nxt = S_RESULT;
      end
      default: begin
        if (res_valid && res_ready) state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 2'd0;
      wdog        <= '0;
      res_data    <= '0;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
    end else begin
      // 2-bit counter wraps to 0 on the fourth accept
      if (accept_in) cnt <= cnt + 2'd1;

      if (state == S_START)     wdog <= '0;
      else if (state == S_WAIT) wdog <= wdog + WDW'(1);

      if (finish_hit) begin
        res_data    <= max;
        res_timeout <= 1'b0;
        res_valid   <= 1'b1;
      end else if (expire) begin
        res_data    <= '0;
        res_timeout <= 1'b1;
        res_valid   <= 1'b1;
      end else if (state == S_RESULT && res_ready) begin
        res_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maxnet_io_sequencer.sv
// tb/tb_maxnet_io_sequencer.sv - self-checking bench for maxnet_io_sequencer
module tb_maxnet_io_sequencer;

  localparam int W        = 5;
  localparam int SETTLE   = 2;
  localparam int MAX_WAIT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] X1, X2, X3, X4;
  logic         start;
  logic         finish;
  logic [W-1:0] mx;
  logic [W-1:0] res_data;
  logic         res_valid;
  logic         res_ready;
  logic         res_timeout;

  int tests = 0;
  int fails = 0;

  maxnet_io_sequencer #(.WIDTH(W), .SETTLE(SETTLE), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .X1          (X1),
    .X2          (X2),
    .X3          (X3),
    .X4          (X4),
    .start       (start),
    .finish      (finish),
    .max         (mx),
    .res_data    (res_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_timeout (res_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    in_valid  = 1'b0;
    finish    = 1'b0;
    res_ready = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic chk_x(input string tag, input logic [19:0] vals);
    chk({tag, "_X1"}, X1, vals[4:0]);
    chk({tag, "_X2"}, X2, vals[9:5]);
    chk({tag, "_X3"}, X3, vals[14:10]);
    chk({tag, "_X4"}, X4, vals[19:15]);
  endtask

  // Presents the four values (vals[4:0] first) with random idle gaps; ends in START.
  task automatic load(input logic [19:0] vals, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      repeat (g) step();
      in_data  = vals[5*i +: 5];
      in_valid = 1'b1;
      chk("in_ready_fill", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    chk("start_after_4th", start, 1);
    chk("in_ready_start", in_ready, 0);
    chk_x("load", vals);
  endtask

  // Reference: the result comes from the first WAIT cycle k in [SETTLE, MAX_WAIT-1]
  // with finish high; otherwise the watchdog fires after MAX_WAIT cycles.
  task automatic run_wait(input logic [63:0] mask, input logic [W-1:0] win,
                          input int hold, input logic [19:0] vals);
    int           exp_n;
    logic         exp_to;
    logic [W-1:0] exp_d;
    exp_n  = MAX_WAIT;
    exp_to = 1'b1;
    exp_d  = '0;
    for (int k = MAX_WAIT - 1; k >= SETTLE; k--) begin
      if (mask[k]) begin
        exp_n  = k + 1;
        exp_to = 1'b0;
        exp_d  = win;
      end
    end
    step();
    chk("start_one_cycle", start, 0);
    for (int k = 0; k < exp_n; k++) begin
      finish = mask[k];
      mx     = mask[k] ? win : ~win;
      if (k == exp_n - 1) chk("no_early_result", res_valid, 0);
      step();
    end
    finish = 1'b0;
    mx     = W'($urandom);
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, exp_d);
    chk("res_timeout", res_timeout, exp_to);
    chk("in_ready_result", in_ready, 0);
    chk_x("held", vals);
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_d);
      chk("hold_timeout", res_timeout, exp_to);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask

  initial begin
    logic [19:0] vals;
    logic [63:0] mask;
    int          fc;

    in_data = '0;
    mx      = '0;

    // T1 reset
    do_reset(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start", start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_res_data", res_data, 0);
    chk_x("rst", 20'd0);

    // T2/T3 load 3,9,17,5 then converge to 17 at WAIT cycle 6, hold 3 cycles
    vals = {5'd5, 5'd17, 5'd9, 5'd3};
    load(vals, 0);
    run_wait(64'd1 << 6, 5'd17, 3, vals);

    // T4 finish only inside the settle window -> ignored, watchdog fires
    vals = 20'($urandom);
    load(vals, 1);
    run_wait(64'b11, 5'd21, 1, vals);

    // finish exactly at the first sampled cycle
    vals = 20'($urandom);
    load(vals, 0);
    run_wait(64'd1 << SETTLE, 5'd30, 0, vals);

    // T5 all-zero load, no finish -> timeout; then finish on the last cycle wins
    load(20'd0, 0);
    run_wait(64'd0, 5'd7, 2, 20'd0);
    load(20'd0, 0);
    run_wait(64'd1 << 63, 5'd12, 1, 20'd0);

    // T6a reset mid-WAIT
    vals = 20'($urandom);
    load(vals, 0);
    step();
    repeat (5) step();
    do_reset(1);
    chk("midwait_in_ready", in_ready, 1);
    chk("midwait_res_valid", res_valid, 0);
    chk("midwait_start", start, 0);
    chk_x("midwait", 20'd0);
    vals = {5'd1, 5'd2, 5'd3, 5'd4};
    load(vals, 2);
    run_wait(64'd1 << 10, 5'd4, 0, vals);

    // T6b reset after 2 of 4 inputs with gaps
    in_data = 5'd11; in_valid = 1'b1; step();
    in_valid = 1'b0; step(); step();
    in_data = 5'd22; in_valid = 1'b1; step();
    in_valid = 1'b0;
    do_reset(1);
    chk("partial_in_ready", in_ready, 1);
    chk_x("partial", 20'd0);
    vals = {5'd31, 5'd0, 5'd16, 5'd8};
    load(vals, 2);
    run_wait(64'd1 << 3, 5'd31, 1, vals);

    // randomized transactions
    repeat (8) begin
      vals = 20'($urandom);
      fc   = int'($urandom_range(0, 70));
      mask = (fc < MAX_WAIT) ? (64'd1 << fc) : 64'd0;
      if ($urandom_range(0, 1) == 1) mask = mask | 64'($urandom_range(0, 3));
      load(vals, int'($urandom_range(0, 2)));
      run_wait(mask, W'($urandom), int'($urandom_range(0, 3)), vals);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
